// File: rtl/median_window_feeder_if.sv
// Bundle of command, SRAM read and sorter signals around the 3x3 median window feeder.
// i_start is a single-cycle request, taken only while the feeder is idle (o_busy low); each taken request yields exactly one o_valid pulse.
interface median_window_feeder_if #(
  parameter int ADDR_W = 6,
  parameter int CRD_W  = 3
);
  logic              i_start;
  logic [CRD_W-1:0]  i_row;
  logic [CRD_W-1:0]  i_col;
  logic              o_busy;
  logic              o_sram_ren;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [7:0]        i_sram_rdata;
  logic              o_med_clear;
  logic              o_med_active;
  logic [7:0]        o_med_data;
  logic [7:0]        i_med_median;
  logic [7:0]        o_result;
  logic              o_valid;

  modport slave (
    input  i_start, i_row, i_col, i_sram_rdata, i_med_median,
    output o_busy, o_sram_ren, o_sram_addr, o_med_clear, o_med_active,
           o_med_data, o_result, o_valid
  );

  modport master (
    output i_start, i_row, i_col, i_sram_rdata, i_med_median,
    input  o_busy, o_sram_ren, o_sram_addr, o_med_clear, o_med_active,
           o_med_data, o_result, o_valid
  );
endinterface

// File: rtl/median_window_feeder.sv
// Fetches the 3x3 neighbourhood of a centre pixel from SRAM in raster order,
// streams it into the median sorter (zero for out-of-image taps) and returns the median.
module median_window_feeder #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 6,
  parameter int CRD_W  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  median_window_feeder_if.slave bus,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         k_q;
  logic [CRD_W-1:0]   row_q, col_q;
  logic               tap_vld_q, tap_inb_q;
  logic [7:0]         result_q;
  logic               valid_q;

  logic [1:0]         k_row, k_col;
  logic [CRD_W:0]     nb_r, nb_c;
  logic               tap_inb;
  logic [ADDR_W-1:0]  tap_addr;

  // Neighbour coordinates carry one extra bit so that -1 and overflow past
  // the last row/column both show up with the top bit set.
  always_comb begin
    k_row = 2'(k_q / 4'd3);
    k_col = 2'(k_q % 4'd3);
  end

  assign nb_r = {1'b0, row_q} + (CRD_W+1)'(k_row) - (CRD_W+1)'(1);
  assign nb_c = {1'b0, col_q} + (CRD_W+1)'(k_col) - (CRD_W+1)'(1);

  assign tap_inb = !nb_r[CRD_W] && (nb_r < (CRD_W+1)'(IMG_H)) &&
                   !nb_c[CRD_W] && (nb_c < (CRD_W+1)'(IMG_W));
  assign tap_addr = ADDR_W'(nb_r[CRD_W-1:0]) * ADDR_W'(IMG_W) +
                    ADDR_W'(nb_c[CRD_W-1:0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.i_start) state_d = S_FETCH;
      S_FETCH:   if (k_q == 4'd8) state_d = S_DRAIN;
      S_DRAIN:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Tap counter, latched centre, one-stage push pipeline and result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      k_q       <= 4'd0;
      row_q     <= '0;
      col_q     <= '0;
      tap_vld_q <= 1'b0;
      tap_inb_q <= 1'b0;
      result_q  <= 8'd0;
      valid_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.i_start) begin
        row_q <= bus.i_row;
        col_q <= bus.i_col;
        k_q   <= 4'd0;
      end else if (state_q == S_FETCH) begin
        k_q <= (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
      end
      tap_vld_q <= (state_q == S_FETCH);
      tap_inb_q <= (state_q == S_FETCH) && tap_inb;
      valid_q   <= (state_q == S_CAPTURE);
      if (state_q == S_CAPTURE) result_q <= bus.i_med_median;
    end
  end

  logic              busy_c, ren_c, clear_c;
  logic [ADDR_W-1:0] addr_c;

  always_comb begin
    busy_c  = 1'b0;
    ren_c   = 1'b0;
    clear_c = 1'b0;
    addr_c  = '0;
    case (state_q)
      S_FETCH: begin
        busy_c  = 1'b1;
        ren_c   = tap_inb;
        addr_c  = tap_inb ? tap_addr : '0;
        clear_c = (k_q == 4'd0);
      end
      S_DRAIN, S_CAPTURE: busy_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_busy       = busy_c;
  assign bus.o_sram_ren   = ren_c;
  assign bus.o_sram_addr  = addr_c;
  assign bus.o_med_clear  = clear_c;
  assign bus.o_med_active = tap_vld_q;
  assign bus.o_med_data   = tap_inb_q ? bus.i_sram_rdata : 8'd0;
  assign bus.o_result     = result_q;
  assign bus.o_valid      = valid_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder with SRAM and sorter models and a cycle-level reference model.
module tb_median_window_feeder;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int ADDR_W = 6;
  localparam int CRD_W  = 3;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [1:0] state_dbg;

  median_window_feeder_if #(.ADDR_W(ADDR_W), .CRD_W(CRD_W)) bus();

  median_window_feeder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .CRD_W(CRD_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus),
    .o_state (state_dbg)
  );

  // ---------------- clock/reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- SRAM and sorter models ----------------
  int pix_ofs = 0;

  always @(posedge i_clk)
    if (bus.o_sram_ren) bus.i_sram_rdata <= 8'(int'(bus.o_sram_addr) + pix_ofs);

  function automatic logic [7:0] med_of(input logic [7:0] v[9], input int n);
    logic [7:0] s[9];
    logic [7:0] t;
    s = v;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return (n == 0) ? 8'd0 : s[n/2];
  endfunction

  logic [7:0] s_samp[9];
  int         s_cnt = 0;
  always @(posedge i_clk) begin
    if (bus.o_med_clear) s_cnt = 0;
    else if (bus.o_med_active && s_cnt < 9) begin
      s_samp[s_cnt] = bus.o_med_data;
      s_cnt++;
    end
    bus.i_med_median <= med_of(s_samp, s_cnt);
  end

  // ---------------- reference model ----------------
  // phase 0: idle; 1..9 fetch taps; 10 drain; 11 capture; 12 result cycle (idle)
  int         phase = 0;
  int         m_row, m_col;
  logic [7:0] m_vals[9];
  logic       m_inb[9];
  int         m_addr[9];
  logic [7:0] m_med;
  logic [7:0] exp_result = 8'd0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase = 0;
      exp_result = 8'd0;
    end else begin
      if (phase == 11) exp_result = m_med;
      if ((phase == 0 || phase == 12) && bus.i_start) begin
        m_row = int'(bus.i_row);
        m_col = int'(bus.i_col);
        for (int k = 0; k < 9; k++) begin
          int r, c;
          r = m_row + k / 3 - 1;
          c = m_col + k % 3 - 1;
          m_inb[k]  = (r >= 0) && (r < IMG_H) && (c >= 0) && (c < IMG_W);
          m_addr[k] = m_inb[k] ? r * IMG_W + c : 0;
          m_vals[k] = m_inb[k] ? 8'(m_addr[k] + pix_ofs) : 8'd0;
        end
        m_med = med_of(m_vals, 9);
        phase = 1;
      end else if (phase >= 1 && phase <= 11) phase++;
      else phase = 0;
    end
  end

  // ---------------- scoreboard / monitors ----------------
  logic [ADDR_W-1:0] exp_q[$];
  int                valid_cyc_q[$];
  int                res_q[$];
  int                act_cnt = 0;

  logic       e_ren, e_act;
  int         e_addr;
  logic [7:0] e_data;

  always @(negedge i_clk) begin
    e_ren  = 1'b0;
    e_addr = 0;
    if (phase >= 1 && phase <= 9) begin
      e_ren  = m_inb[phase-1];
      e_addr = m_addr[phase-1];
    end
    e_act  = (phase >= 2 && phase <= 10);
    e_data = e_act ? m_vals[phase-2] : 8'd0;
    chk("busy",   32'(bus.o_busy),       32'(phase >= 1 && phase <= 11));
    chk("clear",  32'(bus.o_med_clear),  32'(phase == 1));
    chk("ren",    32'(bus.o_sram_ren),   32'(e_ren));
    chk("addr",   32'(bus.o_sram_addr),  32'(e_addr));
    chk("active", 32'(bus.o_med_active), 32'(e_act));
    chk("data",   32'(bus.o_med_data),   32'(e_data));
    chk("valid",  32'(bus.o_valid),      32'(phase == 12));
    chk("result", 32'(bus.o_result),     32'(exp_result));

    if (bus.o_sram_ren) begin
      if (exp_q.size() == 0) chk("read_extra", 32'(bus.o_sram_addr), 32'hFFFF);
      else chk("read_addr", 32'(bus.o_sram_addr), 32'(exp_q.pop_front()));
    end
    if (bus.o_med_active) act_cnt++;
    if (bus.o_valid) begin
      valid_cyc_q.push_back(cyc);
      res_q.push_back(int'(bus.o_result));
    end
  end

  // ---------------- driver tasks ----------------
  int c0 = 0;

  task automatic clear_op();
    exp_q.delete();
    valid_cyc_q.delete();
    res_q.delete();
    act_cnt = 0;
  endtask

  task automatic push_addrs(input int a[]);
    foreach (a[i]) exp_q.push_back(ADDR_W'(a[i]));
  endtask

  task automatic start_op(input int r, input int c);
    @(posedge i_clk); #1;
    bus.i_start = 1'b1;
    bus.i_row   = CRD_W'(r);
    bus.i_col   = CRD_W'(c);
    c0 = cyc;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic run_single(input int r, input int c, input int exp_res, input string nm);
    start_op(r, c);
    repeat (16) @(negedge i_clk);
    chk({nm, "_valid_count"}, 32'(valid_cyc_q.size()), 32'd1);
    if (valid_cyc_q.size() >= 1) begin
      chk({nm, "_latency"}, 32'(valid_cyc_q[0] - c0), 32'd12);
      chk({nm, "_res"}, 32'(res_q[0]), 32'(exp_res));
    end
    chk({nm, "_pushes"}, 32'(act_cnt), 32'd9);
    chk({nm, "_reads_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  int c_first;

  initial begin
    bus.i_start = 1'b0;
    bus.i_row   = '0;
    bus.i_col   = '0;
    repeat (3) @(posedge i_clk); #1;
    chk("rst_busy",   32'(bus.o_busy),       32'd0);
    chk("rst_valid",  32'(bus.o_valid),      32'd0);
    chk("rst_result", 32'(bus.o_result),     32'd0);
    chk("rst_active", 32'(bus.o_med_active), 32'd0);
    chk("rst_state",  32'(state_dbg),        32'd0);
    i_rst_n = 1'b1;

    // interior (3,3), pixel = address
    clear_op(); pix_ofs = 0;
    push_addrs('{18, 19, 20, 26, 27, 28, 34, 35, 36});
    run_single(3, 3, 27, "interior");

    // corner (0,0)
    clear_op();
    push_addrs('{0, 1, 8, 9});
    run_single(0, 0, 0, "corner");

    // top edge (0,3), pixel = address + 100
    clear_op(); pix_ofs = 100;
    push_addrs('{2, 3, 4, 10, 11, 12});
    run_single(0, 3, 103, "edge");

    // start pulses while busy are ignored
    clear_op(); pix_ofs = 0;
    push_addrs('{18, 19, 20, 26, 27, 28, 34, 35, 36});
    start_op(3, 3);
    bus.i_start = 1'b1; bus.i_row = 3'd5; bus.i_col = 3'd5;
    repeat (11) @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (6) @(negedge i_clk);
    chk("busy_valid_count", 32'(valid_cyc_q.size()), 32'd1);
    if (res_q.size() >= 1) chk("busy_res", 32'(res_q[0]), 32'd27);
    if (valid_cyc_q.size() >= 1) chk("busy_latency", 32'(valid_cyc_q[0] - c0), 32'd12);
    chk("busy_reads_left", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during FETCH k=4
    clear_op();
    push_addrs('{18, 19, 20, 26});
    start_op(3, 3);
    repeat (4) @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(bus.o_busy),       32'd0);
    chk("mid_rst_ren",    32'(bus.o_sram_ren),   32'd0);
    chk("mid_rst_addr",   32'(bus.o_sram_addr),  32'd0);
    chk("mid_rst_clear",  32'(bus.o_med_clear),  32'd0);
    chk("mid_rst_active", 32'(bus.o_med_active), 32'd0);
    chk("mid_rst_data",   32'(bus.o_med_data),   32'd0);
    chk("mid_rst_valid",  32'(bus.o_valid),      32'd0);
    chk("mid_rst_result", 32'(bus.o_result),     32'd0);
    repeat (2) @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (14) @(negedge i_clk);
    chk("mid_rst_no_valid", 32'(valid_cyc_q.size()), 32'd0);
    chk("mid_rst_reads_left", 32'(exp_q.size()), 32'd0);
    clear_op();
    push_addrs('{18, 19, 20, 26, 27, 28, 34, 35, 36});
    run_single(3, 3, 27, "after_rst");

    // back-to-back: (3,3) then (7,7) started in the result cycle
    clear_op();
    push_addrs('{18, 19, 20, 26, 27, 28, 34, 35, 36, 54, 55, 62, 63});
    start_op(3, 3);
    c_first = c0;
    repeat (11) @(posedge i_clk); #1;
    bus.i_start = 1'b1; bus.i_row = 3'd7; bus.i_col = 3'd7;
    @(posedge i_clk); #1;
    bus.i_start = 1'b0;
    repeat (16) @(negedge i_clk);
    chk("b2b_valid_count", 32'(valid_cyc_q.size()), 32'd2);
    if (valid_cyc_q.size() >= 2) begin
      chk("b2b_first_cycle",  32'(valid_cyc_q[0] - c_first), 32'd12);
      chk("b2b_second_cycle", 32'(valid_cyc_q[1] - c_first), 32'd24);
      chk("b2b_first_res",  32'(res_q[0]), 32'd27);
      chk("b2b_second_res", 32'(res_q[1]), 32'd0);
    end
    chk("b2b_pushes", 32'(act_cnt), 32'd18);
    chk("b2b_reads_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
# median_window_feeder

Sequencer that drives the 3x3 median sorter from the image SRAM. On a start request it fetches the nine neighbours of a centre pixel in raster order and streams them into the sorter, one sample per cycle. It clears the sorter before the first sample, substitutes zero for out-of-image neighbours, and returns the settled median with a one-cycle valid pulse. It sits between the command controller and the sorter/SRAM pair; the sorter itself (clear, active, data in, median out, registered) is unchanged.

## Interface
- IMG_W, 8, image width in pixels
- IMG_H, 8, image height in pixels
- ADDR_W, 6, SRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- CRD_W, 3, row/column coordinate width
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  request; sampled only in IDLE
- i_row  in  CRD_W  centre row, latched with i_start
- i_col  in  CRD_W  centre column, latched with i_start
- o_busy  out  1  high from the cycle after accepted start until the cycle o_valid rises
- o_sram_ren  out  1  SRAM read enable; read data appears exactly one cycle later
- o_sram_addr  out  ADDR_W  read address = row*IMG_W + col
- i_sram_rdata  in  8  SRAM read data
- o_med_clear  out  1  to sorter clear; one-cycle pulse
- o_med_active  out  1  to sorter active; one per pushed sample
- o_med_data  out  8  to sorter data
- i_med_median  in  8  sorter median output (registered in sorter)
- o_result  out  8  captured median; holds until next capture
- o_valid  out  1  one-cycle pulse, o_result valid

## Operation
- States: IDLE, FETCH (tap counter k = 0..8), DRAIN, CAPTURE.
- IDLE: i_start=1 latches i_row/i_col, sets k=0, and moves to FETCH. i_start is ignored in all other states.
- FETCH, tap k:
  - Neighbour offset is (dr, dc) = (k/3 - 1, k%3 - 1): order (-1,-1),(-1,0),(-1,+1),(0,-1),(0,0) … (+1,+1).
  - Neighbour coordinates are computed with CRD_W+1 signed bits.
  - In bounds means 0 <= r < IMG_H and 0 <= c < IMG_W.
  - In bounds: o_sram_ren=1 and o_sram_addr = r*IMG_W + c.
  - Out of bounds: o_sram_ren=0 and o_sram_addr=0.
  - k=8 goes to DRAIN.
- o_med_clear=1 only in FETCH k=0.
- A one-stage pipeline (valid bit, in-bounds bit) follows each tap by one cycle:
  - In the cycle after any FETCH tap: o_med_active=1.
  - o_med_data = i_sram_rdata if that tap was in bounds, else 8'd0.
  - Otherwise o_med_active=0 and o_med_data=0.
- Nine pushes occur: FETCH k=1..8 cycles plus the DRAIN cycle. DRAIN goes to CAPTURE.
- CAPTURE: at its closing edge, o_result <= i_med_median and o_valid <= 1. Next state is IDLE.
- Outputs not listed for a state are 0.
- Reset (any time, including mid-FETCH):
  - State returns to IDLE, k=0, pipeline bits 0.
  - o_result=0, o_valid=0, o_busy=0.
  - o_sram_ren, o_med_clear, o_med_active and o_med_data are all 0.
  - Sorter contents are left stale; the next operation's clear discards them.
- The sorter is never cleared and pushed in the same cycle, since the first push is one cycle after the clear.

## Timing
- Cycle 0: i_start=1 in IDLE.
- Cycles 1–9: FETCH k=0..8. o_med_clear is high in cycle 1.
- Cycles 2–10: o_med_active high (nine pushes). Cycle 10 is DRAIN.
- Cycle 11: CAPTURE; i_med_median reflects all nine samples.
- Cycle 12: o_valid=1 with o_result valid. State is IDLE and o_busy=0, so a new i_start in cycle 12 is accepted.
- Throughput: one median per 12 cycles back-to-back. Latency is start-to-valid = 12 cycles.
- o_busy is high in cycles 1–11.

## Test plan
- Interior: pixel value = address, IMG 8x8, centre (3,3) -> nine SRAM reads at addresses 18,19,20,26,27,28,34,35,36; o_result=27 with o_valid in cycle 12.
- Corner: centre (0,0), pixel = address -> reads only at addresses 0,1,8,9; five zero pushes at taps 0,1,2,3,6; o_result=0.
- Edge: centre (0,3), pixel = address+100 -> three zero pushes, then 102,103,104,110,111,112; o_result=103; o_med_active high for exactly 9 cycles.
- Busy start: i_start pulsed in cycles 1–11 with other coordinates -> ignored. Result matches the first request and exactly one o_valid pulse occurs.
- Reset mid-FETCH (k=4): assert i_rst_n=0 asynchronously -> all outputs 0 immediately, no o_valid. A new start after release at centre (3,3) returns 27.
- Back-to-back: start (3,3) then start in cycle 12 at (7,7), pixel = address -> o_valid in cycles 12 and 24. Second result: neighbours 54,55,62,63 plus five zeros, so o_result=0.
